uart_tx_arbiter: RTL and testbench

Packet-granular round-robin arbiter and sequencer that shares one UART byte transmitter between `N_REQ` message sources. Each source presents a valid/ready byte stream with an end-of-message marker. The arbiter grants one source for a whole message and issues one `tx_start` per byte to the downstream byte engine. It throttles issue on the engine's `tx_busy` and rotates priority after every message, so no two sources' characters interleave on the serial line.

---
 rtl/uart_arb_pkg.sv | 15 +
 rtl/uart_rr_picker.sv | 50 +++++
 rtl/uart_tx_arbiter.sv | 172 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the UART transmit arbiter: FSM state encoding,
// byte width and default parameter values.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        WAIT_ACK = 2'd2
    } arb_state_t;

    localparam int BYTE_W                 = 8;
    localparam int DEFAULT_N_REQ          = 4;
    localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker: rotates the request vector so rr_ptr sits at
// bit 0, priority-encodes the lowest set bit, then maps the offset back to an index.
module uart_rr_picker #(
    parameter  int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic             found,
    output logic [IDX_W-1:0] win_idx
);

    logic [N_REQ-1:0] rotated;
    logic [IDX_W-1:0] offset;
    logic [IDX_W:0]   sum;
    logic [IDX_W:0]   win_sum;

    always_comb begin
        rotated = '0;
        sum     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            sum = {1'b0, rr_ptr} + (IDX_W+1)'(i);
            if (sum >= (IDX_W+1)'(N_REQ)) begin
                sum = sum - (IDX_W+1)'(N_REQ);
            end
            rotated[i] = req[sum[IDX_W-1:0]];
        end
    end

    // Downward scan so the lowest set offset is the one left standing.
    always_comb begin
        found  = 1'b0;
        offset = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                found  = 1'b1;
                offset = IDX_W'(i);
            end
        end
    end

    always_comb begin
        win_sum = {1'b0, rr_ptr} + {1'b0, offset};
        if (win_sum >= (IDX_W+1)'(N_REQ)) begin
            win_sum = win_sum - (IDX_W+1)'(N_REQ);
        end
        win_idx = win_sum[IDX_W-1:0];
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter feeding one UART byte engine; a grant is held
// for a whole message. Optional stall timeout is built when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter  int N_REQ          = DEFAULT_N_REQ,
    parameter  int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    localparam int IDX_W          = $clog2(N_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [BYTE_W*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]          req_last,
    output logic [N_REQ-1:0]          req_ready,
    output logic [BYTE_W-1:0]         tx_data,
    output logic                      tx_start,
    input  logic                      tx_busy,
    output logic                      grant_active,
    output logic [IDX_W-1:0]          grant_id,
    output logic                      timeout_pulse,
    output arb_state_t                dbg_state,
    output logic [IDX_W-1:0]          dbg_rr_ptr
);

    // Handshake: a byte of source i transfers in a cycle where req_valid[i] and
    // req_ready[i] are both high; ready is only ever raised for the granted source,
    // in SEND, while the engine is idle, and the source holds valid/data/last until then.

    arb_state_t         state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q;
    logic [IDX_W-1:0]   next_ptr;
    logic               last_q;
    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic               gnt_valid;
    logic               gnt_last;
    logic [BYTE_W-1:0]  gnt_data;
    logic               accept;
    logic               do_grant;
    logic               do_release;
    logic               timeout_hit;

    uart_rr_picker #(.N_REQ(N_REQ)) u_picker (
        .req     (req_valid),
        .rr_ptr  (rr_ptr_q),
        .found   (pick_found),
        .win_idx (pick_idx)
    );

    always_comb begin
        gnt_valid = 1'b0;
        gnt_last  = 1'b0;
        gnt_data  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_id == IDX_W'(i)) begin
                gnt_valid = req_valid[i];
                gnt_last  = req_last[i];
                gnt_data  = req_data[i*BYTE_W +: BYTE_W];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        do_grant   = 1'b0;
        do_release = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    do_grant = 1'b1;
                    state_d  = SEND;
                end
            end
            SEND: begin
                if (gnt_valid && !tx_busy) begin
                    accept  = 1'b1;
                    state_d = WAIT_ACK;
                end else if (timeout_hit) begin
                    do_release = 1'b1;
                    state_d    = IDLE;
                end
            end
            WAIT_ACK: begin
                // Release as soon as the engine owns the last byte; SEND's busy check
                // keeps the next message from overlapping it on the line.
                if (tx_busy) begin
                    if (last_q) begin
                        do_release = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        state_d = SEND;
                    end
                end else if (timeout_hit) begin
                    do_release = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_ready[i] = accept && (grant_id == IDX_W'(i));
        end
    end

    assign next_ptr = (grant_id == IDX_W'(N_REQ - 1)) ? '0 : grant_id + IDX_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            grant_id     <= '0;
            grant_active <= 1'b0;
            tx_start     <= 1'b0;
            tx_data      <= '0;
            last_q       <= 1'b0;
        end else begin
            state_q  <= state_d;
            tx_start <= accept;
            if (accept) begin
                tx_data <= gnt_data;
                last_q  <= gnt_last;
            end
            if (do_grant) begin
                grant_id     <= pick_idx;
                grant_active <= 1'b1;
            end else if (do_release) begin
                grant_active <= 1'b0;
                rr_ptr_q     <= next_ptr;
            end
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt;
    logic            stall;

    assign stall       = ((state_q == SEND) && !gnt_valid) ||
                         ((state_q == WAIT_ACK) && !tx_busy);
    assign timeout_hit = stall && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // Any state change (grant, accept, release, ack) restarts the stall count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt        <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            timeout_pulse <= timeout_hit;
            if (state_d != state_q) begin
                to_cnt <= '0;
            end else if (stall) begin
                to_cnt <= to_cnt + TO_W'(1);
            end
        end
    end
`else
    // No stall limit in this build; the parameter stays for a uniform interface.
    assign timeout_hit   = (TIMEOUT_CYCLES < 0);
    assign timeout_pulse = 1'b0;
`endif

    assign dbg_state  = state_q;
    assign dbg_rr_ptr = rr_ptr_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a 10-cycle busy engine model and a
// scoreboard of expected {grant_id, byte} line entries.
module tb_uart_tx_arbiter;
    import uart_arb_pkg::*;

    localparam int N        = 4;
    localparam int IDX_W    = 2;
    localparam int EW       = IDX_W + 8;
    localparam int BUSY_LEN = 10;
    localparam int TO_CYC   = 16;
    localparam int MAXW     = 400;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [N-1:0]     req_valid;
    logic [8*N-1:0]   req_data;
    logic [N-1:0]     req_last;
    logic [N-1:0]     req_ready;
    logic [7:0]       tx_data;
    logic             tx_start;
    logic             tx_busy;
    logic             grant_active;
    logic [IDX_W-1:0] grant_id;
    logic             timeout_pulse;
    arb_state_t       dbg_state;
    logic [IDX_W-1:0] dbg_rr_ptr;

    int errors = 0;
    int checks = 0;
    int to_pulses = 0;
    int cyc = 0;
    int t0;
    logic [EW-1:0] exp_q[$];
    int start_cyc_q[$];

    uart_tx_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TO_CYC)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .tx_data       (tx_data),
        .tx_start      (tx_start),
        .tx_busy       (tx_busy),
        .grant_active  (grant_active),
        .grant_id      (grant_id),
        .timeout_pulse (timeout_pulse),
        .dbg_state     (dbg_state),
        .dbg_rr_ptr    (dbg_rr_ptr)
    );

    // Clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Engine model: busy rises the cycle after tx_start and lasts BUSY_LEN cycles.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start === 1'b1) begin
                @(posedge clk);
                #1 tx_busy = 1'b1;
                repeat (BUSY_LEN) @(posedge clk);
                #1 tx_busy = 1'b0;
            end
        end
    end

    // Monitor: every start must match the head of the expected queue.
    initial begin : monitor
        logic [EW-1:0] want;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (tx_start) begin
                    check("start_while_busy", tx_busy, 1'b0);
                    start_cyc_q.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_start: got src %0d byte 0x%0h, expected none",
                                 grant_id, tx_data);
                    end else begin
                        want = exp_q.pop_front();
                        check("line_entry", {grant_id, tx_data}, want);
                    end
                end
                if (timeout_pulse) to_pulses++;
            end
        end
    end

    // Driver tasks (called at posedge + #1)
    task automatic send_byte(input int src, input logic [7:0] d, input logic l);
        bit done;
        done = 1'b0;
        req_data[src*8 +: 8] = d;
        req_last[src]        = l;
        req_valid[src]       = 1'b1;
        for (int k = 0; k < MAXW && !done; k++) begin
            @(negedge clk);
            if (req_ready[src]) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL ready_wait: src %0d got no ready in %0d cycles, expected ready", src, MAXW);
        end
        @(posedge clk);
        #1 req_valid[src] = 1'b0;
    endtask

    task automatic send_singles(input int src);
        send_byte(src, 8'h30 + 8'(src), 1'b1);
        send_byte(src, 8'h40 + 8'(src), 1'b1);
    endtask

    task automatic wait_drain(input string name);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 4 * MAXW && !ok; k++) begin
            @(negedge clk);
            ok = (exp_q.size() == 0) && !grant_active && !tx_busy;
        end
        check({name, "_pending"}, exp_q.size(), 0);
        check({name, "_released"}, grant_active, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        req_valid = '0;
        req_last  = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit hit;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_state", dbg_state, IDLE);
        check("rst_rr_ptr", dbg_rr_ptr, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_grant_active", grant_active, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_req_ready", req_ready, 0);
        check("rst_timeout", timeout_pulse, 0);

        // Source 2 sends "HI"
        @(posedge clk);
        #1;
        start_cyc_q.delete();
        exp_q.push_back({2'd2, 8'h48});
        exp_q.push_back({2'd2, 8'h49});
        t0 = cyc;
        req_data[23:16] = 8'h48;
        req_last[2]     = 1'b0;
        req_valid[2]    = 1'b1;
        @(negedge clk);
        check("hi_c0_no_ready", req_ready, 0);
        @(negedge clk);
        check("hi_c1_ready", req_ready, 4'b0100);
        check("hi_c1_grant_id", grant_id, 2);
        check("hi_c1_grant_active", grant_active, 1);
        @(posedge clk);
        #1;
        send_byte(2, 8'h49, 1'b1);
        wait_drain("hi");
        check("hi_starts", start_cyc_q.size(), 2);
        if (start_cyc_q.size() >= 2) begin
            check("hi_start0_cycle", start_cyc_q[0] - t0, 2);
            check("hi_start1_cycle", start_cyc_q[1] - t0, 2 + 1 + BUSY_LEN + 1);
        end
        check("hi_rr_ptr", dbg_rr_ptr, 3);

        // Sources 0 and 1 both with 2-byte messages from reset
        do_reset();
        exp_q.push_back({2'd0, 8'hA0});
        exp_q.push_back({2'd0, 8'hA1});
        exp_q.push_back({2'd1, 8'hB0});
        exp_q.push_back({2'd1, 8'hB1});
        fork
            begin send_byte(0, 8'hA0, 1'b0); send_byte(0, 8'hA1, 1'b1); end
            begin send_byte(1, 8'hB0, 1'b0); send_byte(1, 8'hB1, 1'b1); end
        join
        wait_drain("two_src");
        check("two_src_rr_ptr", dbg_rr_ptr, 2);

        // All four sources streaming single-byte messages
        do_reset();
        for (int r = 0; r < 2; r++) begin
            for (int s = 0; s < N; s++) begin
                exp_q.push_back({IDX_W'(s), 8'h30 + 8'(16 * r + s)});
            end
        end
        fork
            send_singles(0);
            send_singles(1);
            send_singles(2);
            send_singles(3);
        join
        wait_drain("rr4");
        check("rr4_rr_ptr", dbg_rr_ptr, 0);

        // Mid-message gap on source 1 while source 2 waits
        do_reset();
        exp_q.push_back({2'd1, 8'h10});
        exp_q.push_back({2'd1, 8'h11});
        exp_q.push_back({2'd1, 8'h12});
        exp_q.push_back({2'd2, 8'h20});
        fork
            begin
                send_byte(1, 8'h10, 1'b0);
                send_byte(1, 8'h11, 1'b0);
                repeat (2) @(negedge clk);
                for (int k = 0; k < MAXW && tx_busy; k++) @(negedge clk);
                for (int g = 0; g < 5; g++) begin
                    @(negedge clk);
                    check("gap_no_start", tx_start, 0);
                    check("gap_blocked", req_ready, 0);
                    check("gap_grant", {grant_active, grant_id}, {1'b1, 2'd1});
                end
                @(posedge clk);
                #1;
                send_byte(1, 8'h12, 1'b1);
            end
            send_byte(2, 8'h20, 1'b1);
        join
        wait_drain("gap");
        check("gap_rr_ptr", dbg_rr_ptr, 3);

`ifdef UART_ARB_TIMEOUT_EN
        // Source 1 stalls mid-message while source 3 waits
        do_reset();
        to_pulses = 0;
        exp_q.push_back({2'd1, 8'h51});
        exp_q.push_back({2'd3, 8'h73});
        fork
            send_byte(1, 8'h51, 1'b0);
            send_byte(3, 8'h73, 1'b1);
        join
        wait_drain("timeout");
        check("timeout_pulses", to_pulses, 1);
        check("timeout_grant_id", grant_id, 3);
        check("timeout_rr_ptr", dbg_rr_ptr, 0);
`else
        check("no_timeout_pulses", to_pulses, 0);
`endif

        // Reset while in WAIT_ACK
        do_reset();
        exp_q.push_back({2'd0, 8'h61});
        req_data[7:0] = 8'h61;
        req_last[0]   = 1'b0;
        req_valid[0]  = 1'b1;
        hit = 1'b0;
        for (int k = 0; k < MAXW && !hit; k++) begin
            @(negedge clk);
            if (dbg_state == WAIT_ACK) hit = 1'b1;
        end
        check("rw_reached_wait_ack", hit, 1'b1);
        #1 reset = 1'b1;
        req_valid = '0;
        #1;
        check("rw_state", dbg_state, IDLE);
        check("rw_tx_start", tx_start, 0);
        check("rw_tx_data", tx_data, 8'h00);
        check("rw_grant", {grant_active, grant_id}, 0);
        check("rw_rr_ptr", dbg_rr_ptr, 0);
        check("rw_req_ready", req_ready, 0);
        check("rw_timeout", timeout_pulse, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        exp_q.push_back({2'd1, 8'h71});
        exp_q.push_back({2'd2, 8'h72});
        fork
            send_byte(2, 8'h72, 1'b1);
            send_byte(1, 8'h71, 1'b1);
        join
        wait_drain("rw");
        check("rw_final_rr_ptr", dbg_rr_ptr, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
